// File: rtl/mips_pc_unit_if.sv
// Bundles the control, data and status signals exchanged between the
// multicycle control/datapath (master) and the program-counter stage (slave).
interface mips_pc_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  // Control strobes coming from the multicycle control FSM
  logic                  PCWrite;
  logic                  BeqBranch;
  logic                  BneBranch;
  logic                  PCSrc;
  logic                  JumpCtrl;
  logic                  JalCtrl;
  logic                  JrCtrl;

  // Datapath values feeding the next-PC selection
  logic                  Zero;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic [DATA_WIDTH-1:0] RegA;
  logic [25:0]           InstrIndex;

  // Registered state published by the PC stage
  logic [DATA_WIDTH-1:0] PC;
  logic [DATA_WIDTH-1:0] ALUOut;
  logic [DATA_WIDTH-1:0] LinkAddr;
  logic                  PCUpdated;
  logic                  Misalign;
  logic [CNT_WIDTH-1:0]  BranchCount;

  modport master (
    output PCWrite, BeqBranch, BneBranch, PCSrc, JumpCtrl, JalCtrl, JrCtrl,
    output Zero, ALUResult, RegA, InstrIndex,
    input  PC, ALUOut, LinkAddr, PCUpdated, Misalign, BranchCount
  );

  modport slave (
    input  PCWrite, BeqBranch, BneBranch, PCSrc, JumpCtrl, JalCtrl, JrCtrl,
    input  Zero, ALUResult, RegA, InstrIndex,
    output PC, ALUOut, LinkAddr, PCUpdated, Misalign, BranchCount
  );
endinterface

// File: rtl/mips_pc_unit.sv
// Program-counter stage of the multicycle MIPS datapath. Holds the PC, the
// ALUOut and jal link registers, picks the next PC (sequential, branch, j/jal,
// jr), refuses to load misaligned targets and counts taken branches.
module mips_pc_unit #(
  parameter int                      DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]   RESET_PC   = 'h0040_0000,
  parameter int                      CNT_WIDTH  = 16
) (
  input  logic            clk,
  input  logic            reset,
  mips_pc_unit_if.slave   bus
);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] aluOut_q, aluOut_d;
  logic [DATA_WIDTH-1:0] link_q, link_d;
  logic                  updated_q, updated_d;
  logic                  misalign_q, misalign_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] nextPc;
  logic                  takeBeq;
  logic                  takeBne;
  logic                  takeBranch;
  logic                  load;
  logic                  bad;

  // Next-PC selection: jr beats j/jal, which beats the ALUOut/ALUResult choice.
  // The j/jal target keeps the upper nibble of the PC, which already holds PC+4.
  always_comb begin
    nextPc = bus.ALUResult;
    if (bus.JrCtrl) begin
      nextPc = bus.RegA;
    end else if (bus.JumpCtrl) begin
      nextPc = {pc_q[DATA_WIDTH-1:28], bus.InstrIndex, 2'b00};
    end else if (bus.PCSrc) begin
      nextPc = aluOut_q;
    end
  end

  // Load decision. beq and bne are ORed independently, so the illegal
  // both-set encoding always resolves to a taken branch.
  always_comb begin
    takeBeq    = bus.BeqBranch & bus.Zero;
    takeBne    = bus.BneBranch & ~bus.Zero;
    takeBranch = takeBeq | takeBne;
    load       = bus.PCWrite | takeBranch;
    bad        = load & (nextPc[1:0] != 2'b00);
  end

  // Next-state values for every register of the stage.
  always_comb begin
    pc_d       = pc_q;
    aluOut_d   = bus.ALUResult;
    link_d     = link_q;
    updated_d  = load & ~bad;
    misalign_d = misalign_q | bad;
    cnt_d      = cnt_q;
    if (load && !bad) begin
      pc_d = nextPc;
    end
    if (bus.JalCtrl) begin
      link_d = pc_q;
    end
    if (takeBranch && !bad && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // State update; reset wins over any pending load on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      aluOut_q   <= '0;
      link_q     <= '0;
      updated_q  <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      aluOut_q   <= aluOut_d;
      link_q     <= link_d;
      updated_q  <= updated_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.PC          = pc_q;
  assign bus.ALUOut      = aluOut_q;
  assign bus.LinkAddr    = link_q;
  assign bus.PCUpdated   = updated_q;
  assign bus.Misalign    = misalign_q;
  assign bus.BranchCount = cnt_q;

endmodule

// File: tb/tb_mips_pc_unit.sv
// Bench for mips_pc_unit: directed scenarios from the block's behaviour list
// followed by randomized traffic checked against an abstract reference model.
module tb_mips_pc_unit;
  localparam int          DW       = 32;
  localparam int          CW       = 2;
  localparam logic [31:0] RST_PC   = 32'h0040_0000;

  logic clk;
  logic reset;
  int   testsRun;
  int   failCount;

  mips_pc_unit_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  mips_pc_unit #(.DATA_WIDTH(DW), .RESET_PC(RST_PC), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0]   mPc, mAluOut, mLink;
  logic          mUpd, mMis;
  int            mCnt;
  localparam int CNT_MAX = (1 << CW) - 1;

  // Apply one clock edge worth of architectural rules to the model.
  task automatic modelStep();
    logic [31:0] target;
    bit          taken, doLoad, misaligned;
    if (reset) begin
      mPc = RST_PC; mAluOut = 0; mLink = 0; mUpd = 0; mMis = 0; mCnt = 0;
    end else begin
      if (bus.JrCtrl)        target = bus.RegA;
      else if (bus.JumpCtrl) target = (mPc & 32'hF000_0000) + 32'(bus.InstrIndex) * 4;
      else if (bus.PCSrc)    target = mAluOut;
      else                   target = bus.ALUResult;
      taken      = (bus.BeqBranch && bus.Zero) || (bus.BneBranch && !bus.Zero);
      doLoad     = bus.PCWrite || taken;
      misaligned = doLoad && (target % 4 != 0);
      if (bus.JalCtrl) mLink = mPc;
      mUpd = doLoad && !misaligned;
      if (misaligned) mMis = 1;
      if (taken && !misaligned && mCnt < CNT_MAX) mCnt = mCnt + 1;
      if (doLoad && !misaligned) mPc = target;
      mAluOut = bus.ALUResult;
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic applyIdle();
    bus.PCWrite = 0; bus.BeqBranch = 0; bus.BneBranch = 0; bus.PCSrc = 0;
    bus.JumpCtrl = 0; bus.JalCtrl = 0; bus.JrCtrl = 0; bus.Zero = 0;
    bus.ALUResult = 32'h0; bus.RegA = 32'h0; bus.InstrIndex = 26'h0;
  endtask

  task automatic test_reset();
    applyIdle();
    reset = 1; bus.PCWrite = 1; bus.ALUResult = 32'h100;
    tick(); tick();
    testsRun++;
    if (bus.PC !== RST_PC) begin failCount++; $display("[TB] FAIL reset_pc: got %h expected %h", bus.PC, RST_PC); end
    testsRun++;
    if ({bus.ALUOut, bus.LinkAddr} !== 64'h0) begin failCount++; $display("[TB] FAIL reset_regs: got %h/%h expected 0/0", bus.ALUOut, bus.LinkAddr); end
    testsRun++;
    if ({bus.PCUpdated, bus.Misalign, bus.BranchCount} !== 4'b0) begin
      failCount++; $display("[TB] FAIL reset_flags: got upd=%b mis=%b cnt=%0d expected 0/0/0", bus.PCUpdated, bus.Misalign, bus.BranchCount);
    end
    reset = 0; bus.PCWrite = 1; bus.PCSrc = 0; bus.ALUResult = 32'h0040_0004;
    tick();
    testsRun++;
    if (bus.PC !== 32'h0040_0004 || bus.PCUpdated !== 1'b1) begin
      failCount++; $display("[TB] FAIL first_load: got pc=%h upd=%b expected 00400004/1", bus.PC, bus.PCUpdated);
    end
    applyIdle();
    tick();
    testsRun++;
    if (bus.PC !== 32'h0040_0004 || bus.PCUpdated !== 1'b0) begin
      failCount++; $display("[TB] FAIL upd_pulse: got pc=%h upd=%b expected 00400004/0", bus.PC, bus.PCUpdated);
    end
  endtask

  task automatic test_branches();
    applyIdle(); bus.ALUResult = 32'h0040_0040; tick();
    bus.BeqBranch = 1; bus.PCSrc = 1; bus.Zero = 1; bus.ALUResult = 32'h1234_5678;
    tick();
    testsRun++;
    if (bus.PC !== 32'h0040_0040 || bus.BranchCount !== 2'd1) begin
      failCount++; $display("[TB] FAIL beq_taken: got pc=%h cnt=%0d expected 00400040/1", bus.PC, bus.BranchCount);
    end
    applyIdle(); bus.ALUResult = 32'h0040_0080; tick();
    bus.BeqBranch = 1; bus.PCSrc = 1; bus.Zero = 0; bus.ALUResult = 32'h0;
    tick();
    testsRun++;
    if (bus.PC !== 32'h0040_0040 || bus.BranchCount !== 2'd1 || bus.PCUpdated !== 1'b0) begin
      failCount++; $display("[TB] FAIL beq_not_taken: got pc=%h cnt=%0d upd=%b expected 00400040/1/0", bus.PC, bus.BranchCount, bus.PCUpdated);
    end
    applyIdle(); bus.ALUResult = 32'h0040_0100; tick();
    bus.BneBranch = 1; bus.PCSrc = 1; bus.Zero = 0; bus.ALUResult = 32'h0;
    tick();
    testsRun++;
    if (bus.PC !== 32'h0040_0100 || bus.BranchCount !== 2'd2) begin
      failCount++; $display("[TB] FAIL bne_taken: got pc=%h cnt=%0d expected 00400100/2", bus.PC, bus.BranchCount);
    end
    applyIdle(); bus.ALUResult = 32'h0040_0200; tick();
    bus.BneBranch = 1; bus.PCSrc = 1; bus.Zero = 1;
    tick();
    testsRun++;
    if (bus.PC !== 32'h0040_0100 || bus.BranchCount !== 2'd2) begin
      failCount++; $display("[TB] FAIL bne_not_taken: got pc=%h cnt=%0d expected 00400100/2", bus.PC, bus.BranchCount);
    end
  endtask

  task automatic test_jal_jr();
    applyIdle(); bus.PCWrite = 1; bus.ALUResult = 32'h0040_0008; tick();
    applyIdle();
    bus.JumpCtrl = 1; bus.JalCtrl = 1; bus.PCWrite = 1; bus.InstrIndex = 26'h010_0010;
    bus.ALUResult = 32'h0000_0500;
    tick();
    testsRun++;
    if (bus.PC !== 32'h0040_0040 || bus.LinkAddr !== 32'h0040_0008) begin
      failCount++; $display("[TB] FAIL jal: got pc=%h link=%h expected 00400040/00400008", bus.PC, bus.LinkAddr);
    end
    applyIdle();
    bus.JrCtrl = 1; bus.JumpCtrl = 1; bus.PCWrite = 1; bus.RegA = 32'h0040_0008;
    bus.InstrIndex = 26'h000_0100;
    tick();
    testsRun++;
    if (bus.PC !== 32'h0040_0008 || bus.LinkAddr !== 32'h0040_0008) begin
      failCount++; $display("[TB] FAIL jr: got pc=%h link=%h expected 00400008/00400008", bus.PC, bus.LinkAddr);
    end
  endtask

  task automatic test_misalign();
    applyIdle(); bus.PCWrite = 1; bus.JrCtrl = 1; bus.RegA = 32'h0040_0006;
    tick();
    testsRun++;
    if (bus.PC !== 32'h0040_0008 || bus.Misalign !== 1'b1 || bus.PCUpdated !== 1'b0) begin
      failCount++; $display("[TB] FAIL misalign_hold: got pc=%h mis=%b upd=%b expected 00400008/1/0", bus.PC, bus.Misalign, bus.PCUpdated);
    end
    bus.RegA = 32'h0040_0010;
    tick();
    testsRun++;
    if (bus.PC !== 32'h0040_0010 || bus.Misalign !== 1'b1 || bus.PCUpdated !== 1'b1) begin
      failCount++; $display("[TB] FAIL misalign_sticky: got pc=%h mis=%b upd=%b expected 00400010/1/1", bus.PC, bus.Misalign, bus.PCUpdated);
    end
    applyIdle(); reset = 1; tick(); reset = 0;
    testsRun++;
    if (bus.Misalign !== 1'b0) begin failCount++; $display("[TB] FAIL misalign_clear: got %b expected 0", bus.Misalign); end
  endtask

  task automatic test_saturation();
    logic [1:0] expCnt [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    for (int i = 0; i < 4; i++) begin
      applyIdle(); bus.BeqBranch = 1; bus.Zero = 1; bus.ALUResult = 32'h0040_1000 + 32'(i) * 16;
      tick();
      testsRun++;
      if (bus.BranchCount !== expCnt[i]) begin
        failCount++; $display("[TB] FAIL saturate_%0d: got %0d expected %0d", i, bus.BranchCount, expCnt[i]);
      end
    end
    applyIdle(); bus.BeqBranch = 1; bus.Zero = 1; bus.ALUResult = 32'h0040_2000; reset = 1;
    tick(); reset = 0;
    testsRun++;
    if (bus.PC !== RST_PC || bus.BranchCount !== 2'd0) begin
      failCount++; $display("[TB] FAIL reset_midop: got pc=%h cnt=%0d expected %h/0", bus.PC, bus.BranchCount, RST_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      bus.PCWrite   = ($urandom_range(0, 3) == 0);
      bus.BeqBranch = ($urandom_range(0, 4) == 0);
      bus.BneBranch = ($urandom_range(0, 4) == 0);
      bus.PCSrc     = 1'($urandom);
      bus.JumpCtrl  = ($urandom_range(0, 3) == 0);
      bus.JalCtrl   = ($urandom_range(0, 3) == 0);
      bus.JrCtrl    = ($urandom_range(0, 5) == 0);
      bus.Zero      = 1'($urandom);
      r = $urandom; if ($urandom_range(0, 9) != 0) r[1:0] = 2'b00; bus.ALUResult = r;
      r = $urandom; if ($urandom_range(0, 9) != 0) r[1:0] = 2'b00; bus.RegA = r;
      bus.InstrIndex = 26'($urandom);
      tick();
      testsRun++;
      if (bus.PC !== mPc || bus.ALUOut !== mAluOut || bus.LinkAddr !== mLink) begin
        failCount++; $display("[TB] FAIL rand_regs_%0d: got pc=%h alu=%h link=%h expected %h/%h/%h",
                              i, bus.PC, bus.ALUOut, bus.LinkAddr, mPc, mAluOut, mLink);
      end
      testsRun++;
      if (bus.PCUpdated !== mUpd || bus.Misalign !== mMis || bus.BranchCount !== CW'(mCnt)) begin
        failCount++; $display("[TB] FAIL rand_flags_%0d: got upd=%b mis=%b cnt=%0d expected %b/%b/%0d",
                              i, bus.PCUpdated, bus.Misalign, bus.BranchCount, mUpd, mMis, mCnt);
      end
    end
    reset = 0;
  endtask

  initial begin
    clk = 0; reset = 1; testsRun = 0; failCount = 0;
    mPc = 0; mAluOut = 0; mLink = 0; mUpd = 0; mMis = 0; mCnt = 0;
    applyIdle();
    test_reset();
    test_branches();
    test_jal_jr();
    test_misalign();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
